// File: rtl/branch_resolve_unit_if.sv
// Bundles the prediction, resolve, training and redirect signals of branch_resolve_unit.
// Optional perf counter lines are present only when BRU_PERF_CNT_EN is defined.
interface branch_resolve_unit_if
`ifdef BRU_PERF_CNT_EN
   #(parameter int CNT_W = 32)
`endif
   ;
   logic        pipe_stall;
   logic        if_valid;
   logic        if_predict_taken;
   logic [31:0] if_predict_addr;
   logic        ex_valid;
   logic        ex_is_branch;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        update_en;
   logic        branch_outcome;
   logic        predict_outcome;
   logic [31:0] update_addr;
   logic [31:0] pc_cur_ex;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush;
`ifdef BRU_PERF_CNT_EN
   logic [CNT_W-1:0] perf_branches;
   logic [CNT_W-1:0] perf_mispredicts;
`endif

   modport master (
      output pipe_stall, if_valid, if_predict_taken, if_predict_addr,
             ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
      input  update_en, branch_outcome, predict_outcome, update_addr,
             pc_cur_ex, redirect_valid, redirect_pc, flush
`ifdef BRU_PERF_CNT_EN
      , input perf_branches, perf_mispredicts
`endif
   );

   modport slave (
      input  pipe_stall, if_valid, if_predict_taken, if_predict_addr,
             ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
      output update_en, branch_outcome, predict_outcome, update_addr,
             pc_cur_ex, redirect_valid, redirect_pc, flush
`ifdef BRU_PERF_CNT_EN
      , output perf_branches, perf_mispredicts
`endif
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: carries IF predictions to EX, trains the predictor and
// redirects/flushes the front end on mispredict. BRU_PERF_CNT_EN adds saturating perf counters.
module branch_resolve_unit #(
   parameter int PIPE_DEPTH   = 2,
   parameter int FLUSH_CYCLES = 2
`ifdef BRU_PERF_CNT_EN
   ,
   parameter int CNT_W        = 32
`endif
) (
   input logic                  clk,
   input logic                  rst_n,
   branch_resolve_unit_if.slave bus
);

   typedef enum logic {IDLE, FLUSH} state_t;

   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   state_t          state;
   state_t          state_next;
   logic [FC_W-1:0] flush_cnt;
   logic [FC_W-1:0] flush_cnt_next;

   logic        stage_valid [PIPE_DEPTH];
   logic        stage_taken [PIPE_DEPTH];
   logic [31:0] stage_addr  [PIPE_DEPTH];

   logic        pred_taken;
   logic [31:0] pred_addr;
   logic        resolve;
   logic        mis;
   logic        flushing;

   // An empty EX-side slot behaves like a not-taken prediction to address 0.
   assign pred_taken = stage_valid[PIPE_DEPTH-1] & stage_taken[PIPE_DEPTH-1];
   assign pred_addr  = stage_valid[PIPE_DEPTH-1] ? stage_addr[PIPE_DEPTH-1] : 32'd0;
   assign flushing   = (state == FLUSH);
   assign resolve    = bus.ex_valid & bus.ex_is_branch & ~bus.pipe_stall & (state == IDLE);
   assign mis        = (pred_taken != bus.ex_taken) |
                       (bus.ex_taken & (pred_addr != bus.ex_target));
   assign bus.flush  = flushing;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         flush_cnt <= '0;
      end else begin
         state     <= state_next;
         flush_cnt <= flush_cnt_next;
      end
   end

   always_comb begin
      state_next     = state;
      flush_cnt_next = flush_cnt;
      case (state)
         IDLE: begin
            if (resolve && mis) begin
               state_next     = FLUSH;
               flush_cnt_next = FC_W'(FLUSH_CYCLES - 1);
            end
         end
         FLUSH: begin
            if (flush_cnt == '0) begin
               state_next = IDLE;
            end else begin
               flush_cnt_next = flush_cnt - 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Flush wins over loading, so wrong-path fetches never reach EX.
   always_ff @(posedge clk) begin
      if (!rst_n || flushing) begin
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            stage_valid[i] <= 1'b0;
            stage_taken[i] <= 1'b0;
            stage_addr[i]  <= 32'd0;
         end
      end else if (!bus.pipe_stall) begin
         stage_valid[0] <= bus.if_valid;
         stage_taken[0] <= bus.if_predict_taken;
         stage_addr[0]  <= bus.if_predict_addr;
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            stage_valid[i] <= stage_valid[i-1];
            stage_taken[i] <= stage_taken[i-1];
            stage_addr[i]  <= stage_addr[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.update_en       <= 1'b0;
         bus.branch_outcome  <= 1'b0;
         bus.predict_outcome <= 1'b0;
         bus.update_addr     <= 32'd0;
         bus.pc_cur_ex       <= 32'd0;
         bus.redirect_valid  <= 1'b0;
         bus.redirect_pc     <= 32'd0;
      end else begin
         bus.update_en      <= resolve;
         bus.redirect_valid <= resolve & mis;
         if (resolve) begin
            bus.branch_outcome  <= bus.ex_taken;
            bus.predict_outcome <= ~mis;
            bus.update_addr     <= bus.ex_target;
            bus.pc_cur_ex       <= bus.ex_pc;
         end
         if (resolve && mis) begin
            bus.redirect_pc <= bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
         end
      end
   end

`ifdef BRU_PERF_CNT_EN
   logic [CNT_W-1:0] perf_br;
   logic [CNT_W-1:0] perf_mis;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_br  <= '0;
         perf_mis <= '0;
      end else begin
         if (bus.update_en && (perf_br != '1)) begin
            perf_br <= perf_br + 1'b1;
         end
         if (bus.redirect_valid && (perf_mis != '1)) begin
            perf_mis <= perf_mis + 1'b1;
         end
      end
   end

   assign bus.perf_branches    = perf_br;
   assign bus.perf_mispredicts = perf_mis;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed scenarios then random traffic
// checked against a queue-based reference model; perf counters checked under BRU_PERF_CNT_EN.
module tb_branch_resolve_unit;
   localparam int PIPE_DEPTH   = 2;
   localparam int FLUSH_CYCLES = 2;
`ifdef BRU_PERF_CNT_EN
   localparam int CNT_W        = 32;
`endif

   logic clk;
   logic rst_n;

`ifdef BRU_PERF_CNT_EN
   branch_resolve_unit_if #(.CNT_W(CNT_W)) bus ();
   branch_resolve_unit #(.PIPE_DEPTH(PIPE_DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W))
      dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
`else
   branch_resolve_unit_if bus ();
   branch_resolve_unit #(.PIPE_DEPTH(PIPE_DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES))
      dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
`endif

   typedef struct packed {
      logic        rst_n;
      logic        stall;
      logic        if_valid;
      logic        if_taken;
      logic [31:0] if_addr;
      logic        ex_valid;
      logic        ex_is_branch;
      logic [31:0] ex_pc;
      logic        ex_taken;
      logic [31:0] ex_target;
   } stim_t;

   typedef struct packed {
      logic        valid;
      logic        taken;
      logic [31:0] addr;
   } pred_t;

   typedef struct packed {
      int          due;
      logic        outcome;
      logic        correct;
      logic [31:0] addr;
      logic [31:0] pc;
      logic        redir;
      logic [31:0] rpc;
   } exp_t;

   int    vectors = 0;
   int    miscompares = 0;
   int    cycle = 0;
   bit    checking = 0;
   pred_t model_pipe[$];
   int    flush_left = 0;
   int    model_branches = 0;
   int    model_mispredicts = 0;
   exp_t  exp_q[$];
   bit    flush_exp_q[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycle <= cycle + 1;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
      vectors++;
      if (actual !== required) begin
         miscompares++;
         $display("[TB] FAIL %s: actual=0x%08h required=0x%08h cycle %0d",
                  name, actual, required, cycle);
      end
   endtask

   function automatic stim_t idle_stim();
      stim_t s;
      s       = '0;
      s.rst_n = 1'b1;
      return s;
   endfunction

   task automatic model_clear_pipe();
      model_pipe.delete();
      for (int i = 0; i < PIPE_DEPTH; i++) model_pipe.push_back('0);
   endtask

   // Drives one cycle, advances the reference model and queues what the DUT owes us.
   task automatic apply_stimulus(input stim_t s);
      pred_t p;
      exp_t  e;
      bit    cur_flush;
      bit    res;
      bit    mis;
      logic        pt;
      logic [31:0] pa;
      rst_n                = s.rst_n;
      bus.pipe_stall       = s.stall;
      bus.if_valid         = s.if_valid;
      bus.if_predict_taken = s.if_taken;
      bus.if_predict_addr  = s.if_addr;
      bus.ex_valid         = s.ex_valid;
      bus.ex_is_branch     = s.ex_is_branch;
      bus.ex_pc            = s.ex_pc;
      bus.ex_taken         = s.ex_taken;
      bus.ex_target        = s.ex_target;

      cur_flush = (flush_left > 0);
      if (checking) flush_exp_q.push_back(cur_flush);
      res = s.rst_n && s.ex_valid && s.ex_is_branch && !s.stall && !cur_flush;
      mis = 1'b0;
      if (res) begin
         p   = model_pipe[PIPE_DEPTH-1];
         pt  = p.valid & p.taken;
         pa  = p.valid ? p.addr : 32'd0;
         mis = (pt != s.ex_taken) || (s.ex_taken && (pa != s.ex_target));
         e.due     = cycle + 1;
         e.outcome = s.ex_taken;
         e.correct = !mis;
         e.addr    = s.ex_target;
         e.pc      = s.ex_pc;
         e.redir   = mis;
         e.rpc     = s.ex_taken ? s.ex_target : s.ex_pc + 32'd4;
         exp_q.push_back(e);
         model_branches++;
         if (mis) model_mispredicts++;
      end

      if (!s.rst_n) begin
         model_clear_pipe();
         flush_left        = 0;
         model_branches    = 0;
         model_mispredicts = 0;
      end else begin
         if (cur_flush) begin
            model_clear_pipe();
            flush_left--;
         end else if (!s.stall) begin
            model_pipe.push_front({s.if_valid, s.if_taken, s.if_addr});
            void'(model_pipe.pop_back());
         end
         if (res && mis) flush_left = FLUSH_CYCLES;
      end

      @(posedge clk);
      #1;
      if (!s.rst_n) checking = 1;
   endtask

   // Monitor: pops expectations whenever the DUT presents a training pulse.
   always @(negedge clk) begin
      exp_t e;
      bit   f;
      if (checking) begin
         if (flush_exp_q.size() > 0) begin
            f = flush_exp_q.pop_front();
            check_output("flush", 32'(bus.flush), 32'(f));
         end
         if (bus.update_en === 1'b1) begin
            if (exp_q.size() == 0) begin
               check_output("unexpected_update_en", 32'(bus.update_en), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check_output("update_timing", 32'(cycle), 32'(e.due));
               check_output("branch_outcome", 32'(bus.branch_outcome), 32'(e.outcome));
               check_output("predict_outcome", 32'(bus.predict_outcome), 32'(e.correct));
               check_output("update_addr", bus.update_addr, e.addr);
               check_output("pc_cur_ex", bus.pc_cur_ex, e.pc);
               check_output("redirect_valid", 32'(bus.redirect_valid), 32'(e.redir));
               if (e.redir) check_output("redirect_pc", bus.redirect_pc, e.rpc);
            end
         end else begin
            if (exp_q.size() > 0 && exp_q[0].due <= cycle) begin
               check_output("missing_update_en", 32'(bus.update_en), 32'd1);
               void'(exp_q.pop_front());
            end
            check_output("redirect_without_update", 32'(bus.redirect_valid), 32'd0);
         end
      end
   end

   initial begin
      stim_t s;
      model_clear_pipe();
      rst_n                = 1'b0;
      bus.pipe_stall       = 1'b0;
      bus.if_valid         = 1'b0;
      bus.if_predict_taken = 1'b0;
      bus.if_predict_addr  = 32'd0;
      bus.ex_valid         = 1'b0;
      bus.ex_is_branch     = 1'b0;
      bus.ex_pc            = 32'd0;
      bus.ex_taken         = 1'b0;
      bus.ex_target        = 32'd0;
      @(posedge clk);
      #1;

      $display("[TB] reset with if_valid held high");
      s = idle_stim();
      s.rst_n = 1'b0; s.if_valid = 1'b1; s.if_taken = 1'b1; s.if_addr = 32'h100;
      repeat (2) apply_stimulus(s);
      check_output("rst_update_en", 32'(bus.update_en), 32'd0);
      check_output("rst_branch_outcome", 32'(bus.branch_outcome), 32'd0);
      check_output("rst_predict_outcome", 32'(bus.predict_outcome), 32'd0);
      check_output("rst_update_addr", bus.update_addr, 32'd0);
      check_output("rst_pc_cur_ex", bus.pc_cur_ex, 32'd0);
      check_output("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
      check_output("rst_redirect_pc", bus.redirect_pc, 32'd0);
      check_output("rst_flush", 32'(bus.flush), 32'd0);

      s = idle_stim();
      s.ex_valid = 1'b1; s.ex_is_branch = 1'b1; s.ex_pc = 32'h10; s.ex_target = 32'h50;
      apply_stimulus(s);
      check_output("first_resolve_correct", 32'(bus.predict_outcome), 32'd1);
      check_output("first_resolve_no_redirect", 32'(bus.redirect_valid), 32'd0);

      $display("[TB] correct taken prediction");
      s = idle_stim();
      s.if_valid = 1'b1; s.if_taken = 1'b1; s.if_addr = 32'h100;
      apply_stimulus(s);
      repeat (PIPE_DEPTH - 1) apply_stimulus(idle_stim());
      s = idle_stim();
      s.ex_valid = 1'b1; s.ex_is_branch = 1'b1; s.ex_pc = 32'h300;
      s.ex_taken = 1'b1; s.ex_target = 32'h100;
      apply_stimulus(s);
      check_output("hit_update_en", 32'(bus.update_en), 32'd1);
      check_output("hit_predict_outcome", 32'(bus.predict_outcome), 32'd1);
      check_output("hit_redirect_valid", 32'(bus.redirect_valid), 32'd0);
      check_output("hit_flush", 32'(bus.flush), 32'd0);

      $display("[TB] direction mispredict");
      s = idle_stim();
      s.if_valid = 1'b1; s.if_taken = 1'b0; s.if_addr = 32'h80;
      apply_stimulus(s);
      repeat (PIPE_DEPTH - 1) apply_stimulus(idle_stim());
      s = idle_stim();
      s.ex_valid = 1'b1; s.ex_is_branch = 1'b1; s.ex_pc = 32'h200;
      s.ex_taken = 1'b1; s.ex_target = 32'h80;
      apply_stimulus(s);
      check_output("dmiss_redirect_valid", 32'(bus.redirect_valid), 32'd1);
      check_output("dmiss_redirect_pc", bus.redirect_pc, 32'h80);
      check_output("dmiss_predict_outcome", 32'(bus.predict_outcome), 32'd0);
      check_output("dmiss_flush_c1", 32'(bus.flush), 32'd1);
      s.ex_pc = 32'h204;
      apply_stimulus(s);
      check_output("dmiss_flush_c2", 32'(bus.flush), 32'd1);
      check_output("dmiss_no_train_in_flush", 32'(bus.update_en), 32'd0);
      apply_stimulus(idle_stim());
      check_output("dmiss_flush_end", 32'(bus.flush), 32'd0);
      check_output("dmiss_no_late_train", 32'(bus.update_en), 32'd0);

      $display("[TB] taken prediction, not-taken at top of memory");
      s = idle_stim();
      s.if_valid = 1'b1; s.if_taken = 1'b1; s.if_addr = 32'h40;
      apply_stimulus(s);
      repeat (PIPE_DEPTH - 1) apply_stimulus(idle_stim());
      s = idle_stim();
      s.ex_valid = 1'b1; s.ex_is_branch = 1'b1; s.ex_pc = 32'hFFFF_FFFC;
      s.ex_taken = 1'b0; s.ex_target = 32'h1234;
      apply_stimulus(s);
      check_output("wrap_redirect_valid", 32'(bus.redirect_valid), 32'd1);
      check_output("wrap_redirect_pc", bus.redirect_pc, 32'h0);
      repeat (FLUSH_CYCLES) apply_stimulus(idle_stim());

      $display("[TB] stall holds the branch and the pipe");
      s = idle_stim();
      s.if_valid = 1'b1; s.if_taken = 1'b1; s.if_addr = 32'h500;
      apply_stimulus(s);
      repeat (PIPE_DEPTH - 1) apply_stimulus(idle_stim());
      s = idle_stim();
      s.stall = 1'b1; s.if_valid = 1'b1; s.if_addr = 32'h999;
      s.ex_valid = 1'b1; s.ex_is_branch = 1'b1; s.ex_pc = 32'h600;
      s.ex_taken = 1'b1; s.ex_target = 32'h500;
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(s);
         check_output("stall_no_update", 32'(bus.update_en), 32'd0);
      end
      s.stall = 1'b0; s.if_valid = 1'b0;
      apply_stimulus(s);
      check_output("stall_release_update", 32'(bus.update_en), 32'd1);
      check_output("stall_pipe_held", 32'(bus.predict_outcome), 32'd1);
      apply_stimulus(idle_stim());
      check_output("stall_single_pulse", 32'(bus.update_en), 32'd0);

      $display("[TB] random traffic");
      for (int n = 0; n < 400; n++) begin
         s              = idle_stim();
         s.rst_n        = ($urandom_range(0, 63) != 0);
         s.stall        = ($urandom_range(0, 7) == 0);
         s.if_valid     = ($urandom_range(0, 3) != 0);
         s.if_taken     = $urandom_range(0, 1) != 0;
         s.if_addr      = 32'h100 * $urandom_range(1, 4);
         s.ex_valid     = ($urandom_range(0, 3) != 0);
         s.ex_is_branch = ($urandom_range(0, 3) != 0);
         s.ex_pc        = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
         s.ex_taken     = $urandom_range(0, 1) != 0;
         s.ex_target    = 32'h100 * $urandom_range(1, 4);
         apply_stimulus(s);
      end
      repeat (FLUSH_CYCLES + 3) apply_stimulus(idle_stim());
      check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);

`ifdef BRU_PERF_CNT_EN
      begin
         longint cmax;
         longint eb;
         longint em;
         cmax = (longint'(1) << CNT_W) - 1;
         eb   = (model_branches > cmax) ? cmax : longint'(model_branches);
         em   = (model_mispredicts > cmax) ? cmax : longint'(model_mispredicts);
         check_output("perf_branches", 32'(bus.perf_branches), 32'(eb));
         check_output("perf_mispredicts", 32'(bus.perf_mispredicts), 32'(em));
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
